bitwise_logic_serial: RTL and testbench



---
 rtl/logic_pkg.sv | 15 +
 rtl/logic_slice.sv | 24 ++
 rtl/bitwise_logic_serial.sv | 112 +++++++++++
 tb/tb_bitwise_logic_serial.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared definitions for the serial bitwise logic unit: op encodings and FSM state type.
// Optional zero flag in bitwise_logic_serial is enabled by LOGIC_SERIAL_ZERO_FLAG_EN.
package logic_pkg;

    localparam logic [1:0] LOGIC_AND = 2'b00;
    localparam logic [1:0] LOGIC_OR  = 2'b01;
    localparam logic [1:0] LOGIC_XOR = 2'b10;
    localparam logic [1:0] LOGIC_NOR = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-bit logic cell shared by every slice of the serial unit.
module logic_slice
    import logic_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [1:0]       op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            LOGIC_AND: y = a & b;
            LOGIC_OR:  y = a | b;
            LOGIC_XOR: y = a ^ b;
            LOGIC_NOR: y = ~(a | b);
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_serial.sv
// Multi-cycle AND/OR/XOR/NOR unit, SLICE bits per cycle from the LSB, start/done handshake.
// Define LOGIC_SERIAL_ZERO_FLAG_EN to build the zero-flag accumulator; otherwise zero is tied low.
//
// state | meaning
// IDLE  | waiting for start; result/zero hold the last completed operation
// RUN   | one slice written per cycle, idx selects the slice
module bitwise_logic_serial
    import logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int N    = WIDTH / SLICE;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

    state_t            state, state_nxt;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  a_l, b_l;
    logic [1:0]        op_l;
    logic [SLICE-1:0]  a_sl, b_sl, y_sl;
    logic              last;
    logic              slice_zero;

    assign a_sl       = a_l[32'(idx)*SLICE +: SLICE];
    assign b_sl       = b_l[32'(idx)*SLICE +: SLICE];
    assign last       = (state == RUN) && (idx == IDX_LAST);
    assign slice_zero = (y_sl == '0);

    logic_slice #(.SLICE(SLICE)) u_slice (
        .op (op_l),
        .a  (a_sl),
        .b  (b_sl),
        .y  (y_sl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (idx == IDX_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    // Operands are captured only on acceptance, so input activity during RUN is invisible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            a_l    <= '0;
            b_l    <= '0;
            op_l   <= LOGIC_AND;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_l    <= a;
                    b_l    <= b;
                    op_l   <= op;
                    result <= '0;
                    idx    <= '0;
                end
            end else begin
                result[32'(idx)*SLICE +: SLICE] <= y_sl;
                idx <= idx + 1'b1;
                if (last) done <= 1'b1;
            end
        end
    end

`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
    logic zacc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zacc <= 1'b0;
            zero <= 1'b0;
        end else if (state == IDLE) begin
            if (start) zacc <= 1'b1;
        end else begin
            zacc <= zacc & slice_zero;
            if (last) zero <= zacc & slice_zero;
        end
    end
`else
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_bitwise_logic_serial.sv
// Randomised self-checking bench: a 32/8 instance and a 16/16 instance against a word-level model.
module tb_bitwise_logic_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;

    logic        busy32, done32, zero32;
    logic [31:0] result32;
    logic        busy16, done16, zero16;
    logic [15:0] result16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bitwise_logic_serial #(.WIDTH(32), .SLICE(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy32), .done(done32), .result(result32), .zero(zero32)
    );

    bitwise_logic_serial #(.WIDTH(16), .SLICE(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a[15:0]), .b(b[15:0]),
        .busy(busy16), .done(done16), .result(result16), .zero(zero16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    function automatic logic exp_zero(input logic [31:0] r);
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
        return (r == 32'h0);
`else
        return 1'b0;
`endif
    endfunction

    // Entered at #1 after an edge with the selected DUT idle; returns at #1 after
    // the done edge with start low (caller may raise it again for back-to-back).
    task automatic run_op(input bit sel, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input bit interfere);
        int          n;
        logic [31:0] mask, exp_r;
        n     = sel ? 1 : 4;
        mask  = sel ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        exp_r = ref_op(o, av, bv) & mask;
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if (interfere) begin
                start = 1'($urandom_range(0, 1));
                op    = 2'($urandom);
                a     = $urandom;
                b     = $urandom;
            end
            if (k < n) begin
                check("busy_run", sel ? busy16 : busy32, 1'b1);
                check("done_run", sel ? done16 : done32, 1'b0);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("busy_done", sel ? busy16 : busy32, 1'b0);
        check("done",      sel ? done16 : done32, 1'b1);
        check("result",    sel ? {16'h0, result16} : result32, exp_r);
        check("zero",      sel ? zero16 : zero32, exp_zero(exp_r));
    endtask

    task automatic idle_cycle(input bit sel);
        @(posedge clk); #1;
        check("done_fall", sel ? done16 : done32, 1'b0);
        check("busy_idle", sel ? busy16 : busy32, 1'b0);
    endtask

    initial begin
        // reset with random activity on the inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom); op = 2'($urandom); a = $urandom; b = $urandom;
            @(posedge clk); #1;
        end
        check("rst_busy",   busy32,   1'b0);
        check("rst_done",   done32,   1'b0);
        check("rst_zero",   zero32,   1'b0);
        check("rst_result", result32, 32'h0);
        check("rst_busy16", busy16,   1'b0);
        check("rst_res16",  result16, 16'h0);
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_out", {busy32, done32, zero32, result32}, 35'h0);
        end

        run_op(0, 2'b01, 32'h0000_00F0, 32'h0F00_000F, 0);
        idle_cycle(0);
        run_op(0, 2'b11, 32'hFFFF_FFFF, 32'h0, 0);
        idle_cycle(0);
        run_op(0, 2'b10, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0);
        idle_cycle(0);
        run_op(0, 2'b00, 32'h1234_5678, 32'hFFFF_0000, 1);
        idle_cycle(0);

        // back-to-back: second start sits in the first done cycle
        run_op(0, 2'b01, 32'h0000_1111, 32'h2222_0000, 0);
        run_op(0, 2'b00, 32'hFFFF_FFFF, 32'h8000_0001, 0);
        idle_cycle(0);

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if ($urandom_range(0, 4) == 0) begin ra = '1; rb = '0; end
            run_op(0, ro, ra, rb, 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle_cycle(0);
        end
        idle_cycle(0);

        // reset two cycles into RUN
        start = 1'b1; op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h0101_0101;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_result", result32, 32'h0);
        check("abort_busy",   busy32,   1'b0);
        check("abort_done",   done32,   1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("abort_nodone", {busy32, done32}, 2'b00);
        end
        run_op(0, 2'b10, 32'hF0F0_1234, 32'h0F0F_1234, 0);
        idle_cycle(0);

        // N=1 instance
        run_op(1, 2'b01, 32'h0000_00F0, 32'h0000_000F, 0);
        idle_cycle(1);
        start = 1'b1; op = 2'b00; a = 32'h0000_FFFF; b = 32'h0000_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort16_result", {16'h0, result16}, 32'h0);
        check("abort16_busy",   busy16, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort16_nodone", done16, 1'b0);
        run_op(1, 2'b11, 32'h0000_00FF, 32'h0000_FF00, 0);
        idle_cycle(1);
        for (int i = 0; i < 8; i++) begin
            run_op(1, 2'($urandom), $urandom, $urandom, 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle_cycle(1);
        end
        idle_cycle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
